// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution sequencer.
//   state_t : sequencer FSM states
//   KTAPS   : taps per 3x3 kernel/window
//   KDIM    : kernel edge length
//   DATA_W  : memory/accelerator data width
//   ONE     : 1.0 in Q8.24
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KREQ,
        KWAIT,
        PREQ,
        PWAIT,
        FLUSH,
        WRITE,
        FIN
    } state_t;

    localparam int          KTAPS  = 9;
    localparam int          KDIM   = 3;
    localparam int          DATA_W = 32;
    localparam logic [31:0] ONE    = 32'h0100_0000;

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: window/tap counters and address generation.
//   init      : latch bases and dimensions, clear all counters
//   tap_step  : advance to next kernel tap (wraps after the 9th)
//   win_step  : advance to next output position
//   ker_addr  : ker_base + k
//   pix_addr  : img_base + (y+ky)*W + x + kx, row term kept as running sum
//   wr_addr   : out_base + y*(W-2) + x, row term kept as running sum
//   last_tap  : current tap is the 9th
//   last_win  : current window is (W-3, H-3)
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              tap_step,
    input  logic              win_step,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] ker_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    output logic [ADDR_W-1:0] ker_addr,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_tap,
    output logic              last_win
);

    logic [ADDR_W-1:0] img_base_q, ker_base_q, out_base_q;
    logic [DIM_W-1:0]  w_q, h_q;

    logic [3:0]        k_q;
    logic [1:0]        kx_q;
    logic [DIM_W-1:0]  x_q, y_q;
    logic [ADDR_W-1:0] row_base_q;   // y*W
    logic [ADDR_W-1:0] tap_row_q;    // (y+ky)*W
    logic [ADDR_W-1:0] out_row_q;    // y*(W-2)

    logic [ADDR_W-1:0] w_ext;
    logic              x_wrap;

    assign w_ext  = ADDR_W'(w_q);
    assign x_wrap = (x_q == w_q - DIM_W'(3));

    // Job parameters are plain data: captured on init, never reset.
    always_ff @(posedge clk) begin
        if (init) begin
            img_base_q <= img_base;
            ker_base_q <= ker_base;
            out_base_q <= out_base;
            w_q        <= img_width;
            h_q        <= img_height;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || init) begin
            k_q        <= '0;
            kx_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            tap_row_q  <= '0;
            out_row_q  <= '0;
        end else if (tap_step) begin
            if (k_q == 4'(KTAPS - 1)) begin
                // Wrapping the tap also rewinds the row pointer so the next
                // window (or the first after kernel load) starts clean.
                k_q       <= '0;
                kx_q      <= '0;
                tap_row_q <= row_base_q;
            end else begin
                k_q <= k_q + 4'd1;
                if (kx_q == 2'(KDIM - 1)) begin
                    kx_q      <= '0;
                    tap_row_q <= tap_row_q + w_ext;
                end else begin
                    kx_q <= kx_q + 2'd1;
                end
            end
        end else if (win_step) begin
            if (x_wrap) begin
                x_q        <= '0;
                y_q        <= y_q + DIM_W'(1);
                row_base_q <= row_base_q + w_ext;
                tap_row_q  <= row_base_q + w_ext;
                out_row_q  <= out_row_q + w_ext - ADDR_W'(2);
            end else begin
                x_q <= x_q + DIM_W'(1);
            end
        end
    end

    assign ker_addr = ker_base_q + ADDR_W'(k_q);
    assign pix_addr = img_base_q + tap_row_q + ADDR_W'(x_q) + ADDR_W'(kx_q);
    assign wr_addr  = out_base_q + out_row_q + ADDR_W'(x_q);
    assign last_tap = (k_q == 4'(KTAPS - 1));
    assign last_win = x_wrap && (y_q == h_q - DIM_W'(3));

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: memory-master controller that runs a 3x3 convolution
// accelerator over a whole image.
//   start/busy/done/error        : job control toward the HPS registers
//   img_base/ker_base/out_base   : word addresses of image, kernel, output
//   img_width/img_height         : image dimensions (both must be >= 3)
//   mem_*                        : single-outstanding-read Avalon-style master
//   acc_data/acc_valid/acc_filter: beats into the accelerator
//   acc_result                   : accelerator sum, captured in FLUSH
// Kernel is loaded once per job, then each output position costs 9 reads,
// one idle FLUSH beat and one write.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] ker_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [DATA_W-1:0] acc_data,
    output logic              acc_valid,
    output logic              acc_filter,
    input  logic [DATA_W-1:0] acc_result
);

    state_t            state_q, state_d;
    logic              err_q;
    logic [DATA_W-1:0] result_q;

    logic              init, tap_step, win_step;
    logic              dims_bad;
    logic [ADDR_W-1:0] ker_addr, pix_addr, wr_addr;
    logic              last_tap, last_win;

    assign dims_bad = (img_width < DIM_W'(3)) || (img_height < DIM_W'(3));

    conv_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .tap_step   (tap_step),
        .win_step   (win_step),
        .img_base   (img_base),
        .ker_base   (ker_base),
        .out_base   (out_base),
        .img_width  (img_width),
        .img_height (img_height),
        .ker_addr   (ker_addr),
        .pix_addr   (pix_addr),
        .wr_addr    (wr_addr),
        .last_tap   (last_tap),
        .last_win   (last_win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                err_q <= dims_bad;
            end
        end
    end

    // Result is data only; it is read out solely in WRITE after a FLUSH.
    always_ff @(posedge clk) begin
        if (state_q == FLUSH) begin
            result_q <= acc_result;
        end
    end

    always_comb begin
        state_d       = state_q;
        busy          = 1'b1;
        done          = 1'b0;
        error         = err_q;
        mem_addr      = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = '0;
        acc_data      = '0;
        acc_valid     = 1'b0;
        acc_filter    = 1'b0;
        init          = 1'b0;
        tap_step      = 1'b0;
        win_step      = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    init    = 1'b1;
                    state_d = dims_bad ? FIN : KREQ;
                end
            end
            KREQ: begin
                mem_read = 1'b1;
                mem_addr = ker_addr;
                if (!mem_waitrequest) state_d = KWAIT;
            end
            KWAIT: begin
                if (mem_readdatavalid) begin
                    acc_data   = mem_readdata;
                    acc_valid  = 1'b1;
                    acc_filter = 1'b1;
                    tap_step   = 1'b1;
                    state_d    = last_tap ? PREQ : KREQ;
                end
            end
            PREQ: begin
                mem_read = 1'b1;
                mem_addr = pix_addr;
                if (!mem_waitrequest) state_d = PWAIT;
            end
            PWAIT: begin
                if (mem_readdatavalid) begin
                    acc_data  = mem_readdata;
                    acc_valid = 1'b1;
                    tap_step  = 1'b1;
                    state_d   = last_tap ? FLUSH : PREQ;
                end
            end
            FLUSH: begin
                // Idle beat: lets the accelerator restart its beat count.
                state_d = WRITE;
            end
            WRITE: begin
                mem_write     = 1'b1;
                mem_addr      = wr_addr;
                mem_writedata = result_q;
                if (!mem_waitrequest) begin
                    win_step = 1'b1;
                    state_d  = last_win ? FIN : PREQ;
                end
            end
            FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: behavioural memory (optional random stall and
// read latency) plus a behavioural 3x3 Q8.24 MAC accelerator.
module tb_conv_sequencer;

    localparam logic [31:0] Q1 = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] img_base = 32'd16, ker_base = 32'd0, out_base = 32'd0;
    logic [11:0] img_width = 12'd3, img_height = 12'd3;
    logic        busy, done, error;
    logic [31:0] mem_addr, mem_writedata;
    logic        mem_read, mem_write;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;
    logic [31:0] acc_data, acc_result;
    logic        acc_valid, acc_filter;

    always #5 clk = ~clk;

    conv_sequencer #(.ADDR_W(32), .DIM_W(12)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .img_base          (img_base),
        .ker_base          (ker_base),
        .out_base          (out_base),
        .img_width         (img_width),
        .img_height        (img_height),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .acc_data          (acc_data),
        .acc_valid         (acc_valid),
        .acc_filter        (acc_filter),
        .acc_result        (acc_result)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem    [256];
    logic [31:0] outmem [256];
    logic        stall_en = 1'b0;
    int          pend = 0;
    logic [7:0]  paddr = '0;
    int          wr_cnt = 0, kreads = 0;

    always @(posedge clk) begin : memm
        int lat;
        if (reset) begin
            mem_readdatavalid <= 1'b0;
            mem_waitrequest   <= 1'b0;
            pend              <= 0;
        end else begin
            mem_waitrequest   <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_readdatavalid <= 1'b0;
            if (pend != 0) begin
                if (pend == 1) begin
                    mem_readdatavalid <= 1'b1;
                    mem_readdata      <= mem[paddr];
                end
                pend <= pend - 1;
            end
            if (mem_read && !mem_waitrequest) begin
                lat = stall_en ? int'($urandom_range(1, 4)) : 1;
                if (mem_addr < 32'd9) kreads <= kreads + 1;
                if (lat == 1) begin
                    mem_readdatavalid <= 1'b1;
                    mem_readdata      <= mem[mem_addr[7:0]];
                end else begin
                    pend  <= lat - 1;
                    paddr <= mem_addr[7:0];
                end
            end
            if (mem_write && !mem_waitrequest) begin
                outmem[mem_addr[7:0]] <= mem_writedata;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    // ---------------- accelerator model ----------------
    logic [31:0] acc_w [9];
    int          wcnt = 0, pcnt = 0;
    longint      sum = 0;
    logic [31:0] acc_res = '0;
    assign acc_result = acc_res;

    always @(posedge clk) begin : accm
        longint prod;
        if (reset) begin
            wcnt <= 0;
            pcnt <= 0;
            sum  <= 0;
        end else if (acc_valid) begin
            if (acc_filter) begin
                acc_w[wcnt] <= acc_data;
                wcnt <= (wcnt == 8) ? 0 : wcnt + 1;
            end else begin
                prod = (longint'($signed(acc_data)) * longint'($signed(acc_w[pcnt]))) >>> 24;
                if (pcnt == 8) begin
                    acc_res <= 32'(sum + prod);
                    sum     <= 0;
                    pcnt    <= 0;
                end else begin
                    sum  <= sum + prod;
                    pcnt <= pcnt + 1;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    int          done_cnt = 0, acc_cnt = 0, req_cyc = 0, stall_viol = 0;
    logic        prev_stall = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0;

    always @(posedge clk) begin
        if (done)                 done_cnt <= done_cnt + 1;
        if (acc_valid)            acc_cnt  <= acc_cnt + 1;
        if (mem_read | mem_write) req_cyc  <= req_cyc + 1;
        if (!reset && prev_stall &&
            (mem_read != p_rd || mem_write != p_wr || mem_addr != p_addr ||
             (p_wr && mem_writedata != p_wd)))
            stall_viol <= stall_viol + 1;
        prev_stall <= !reset && (mem_read || mem_write) && mem_waitrequest;
        p_rd   <= mem_read;
        p_wr   <= mem_write;
        p_addr <= mem_addr;
        p_wd   <= mem_writedata;
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [11:0] w, h;
        logic        im, km, stall;
        logic [7:0]  obase, nwr;
        logic [31:0] o0, o1, olast;
        logic        err;
        logic [7:0]  nacc, nk;
    } vec_t;

    function automatic vec_t mk(int w, int h, int im, int km, int stall, int obase, int nwr,
                                logic [31:0] o0, logic [31:0] o1, logic [31:0] olast,
                                int err, int nacc, int nk);
        vec_t v;
        v.w = 12'(w); v.h = 12'(h); v.im = 1'(im); v.km = 1'(km); v.stall = 1'(stall);
        v.obase = 8'(obase); v.nwr = 8'(nwr); v.o0 = o0; v.o1 = o1; v.olast = olast;
        v.err = 1'(err); v.nacc = 8'(nacc); v.nk = 8'(nk);
        return v;
    endfunction

    // im=0: pixels 1.0..N row-major; im=1: pixel = col + row*W.
    // km=0: all weights 1.0; km=1: centre 1.0, rest 0.
    task automatic load_job(input vec_t v);
        int w, h;
        w = int'(v.w);
        h = int'(v.h);
        for (int i = 0; i < 9; i++) mem[i] = (v.km == 1'b0 || i == 4) ? Q1 : 32'd0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                mem[16 + r * w + c] = v.im ? 32'((c + r * w) << 24) : 32'((r * w + c + 1) << 24);
        stall_en   = v.stall;
        img_width  = v.w;
        img_height = v.h;
        out_base   = 32'(v.obase);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int c_wr, c_k, c_acc, c_done, c_req, cyc;
        load_job(v);
        c_wr = wr_cnt; c_k = kreads; c_acc = acc_cnt; c_done = done_cnt; c_req = req_cyc;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " error"}, 32'(error), 32'(v.err));
        if (v.err) check({tag, " err_latency"}, 32'(cyc), 32'd1);
        repeat (3) @(negedge clk);
        if (v.err) check({tag, " err_held"}, 32'(error), 32'd1);
        if (v.err) check({tag, " req_cycles"}, 32'(req_cyc - c_req), 32'd0);
        check({tag, " writes"}, 32'(wr_cnt - c_wr), 32'(v.nwr));
        check({tag, " kernel_reads"}, 32'(kreads - c_k), 32'(v.nk));
        check({tag, " acc_pulses"}, 32'(acc_cnt - c_acc), 32'(v.nacc));
        check({tag, " done_pulses"}, 32'(done_cnt - c_done), 32'd1);
        if (v.nwr >= 1) check({tag, " out0"}, outmem[v.obase], v.o0);
        if (v.nwr >= 2) check({tag, " out1"}, outmem[8'(v.obase + 8'd1)], v.o1);
        if (v.nwr >= 1) check({tag, " out_last"}, outmem[8'(v.obase + v.nwr - 8'd1)], v.olast);
    endtask

    vec_t vecs[7];

    initial begin
        int c_wr, c_done, c_k, cyc;

        vecs[0] = mk(3, 3, 0, 0, 0,  64, 1, 32'h2D00_0000, 32'h0, 32'h2D00_0000, 0, 18, 9);
        vecs[1] = mk(4, 3, 1, 1, 0,  80, 2, 32'h0500_0000, 32'h0600_0000, 32'h0600_0000, 0, 27, 9);
        vecs[2] = mk(2, 5, 0, 0, 0,  96, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        vecs[3] = mk(3, 3, 0, 0, 1, 112, 1, 32'h2D00_0000, 32'h0, 32'h2D00_0000, 0, 18, 9);
        vecs[4] = mk(4, 3, 1, 1, 1, 128, 2, 32'h0500_0000, 32'h0600_0000, 32'h0600_0000, 0, 27, 9);
        vecs[5] = mk(5, 4, 1, 1, 1, 144, 6, 32'h0600_0000, 32'h0700_0000, 32'h0D00_0000, 0, 63, 9);
        vecs[6] = mk(3, 2, 0, 0, 0, 160, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);

        repeat (3) @(negedge clk);
        check("reset ctrl", {25'd0, busy, done, error, mem_read, mem_write, acc_valid, acc_filter}, 32'd0);
        check("reset bus", mem_addr | mem_writedata | acc_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Reset during the third pixel wait of the second window.
        load_job(mk(4, 3, 1, 1, 0, 208, 2, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        c_wr = wr_cnt; c_done = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!((wr_cnt - c_wr) == 1 && pcnt == 2 && !mem_read && !mem_write && acc_valid) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("midreset trigger_reached", 32'(cyc < 2000), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset ctrl", {25'd0, busy, done, error, mem_read, mem_write, acc_valid, acc_filter}, 32'd0);
        check("midreset bus", mem_addr | mem_writedata | acc_data, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset no_done", 32'(done_cnt - c_done), 32'd0);
        run_job(mk(4, 3, 1, 1, 0, 224, 2, 32'h0500_0000, 32'h0600_0000, 32'h0600_0000, 0, 27, 9), "post_reset");

        // Start pulses while busy and in the FIN cycle must be ignored.
        load_job(mk(3, 3, 0, 0, 0, 240, 1, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        c_wr = wr_cnt; c_done = done_cnt; c_k = kreads;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy midjob", 32'(busy), 32'd1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("busyjob done", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (40) @(negedge clk);
        check("busyjob busy_after", 32'(busy), 32'd0);
        check("busyjob done_pulses", 32'(done_cnt - c_done), 32'd1);
        check("busyjob writes", 32'(wr_cnt - c_wr), 32'd1);
        check("busyjob kernel_reads", 32'(kreads - c_k), 32'd9);
        check("busyjob out0", outmem[240], 32'h2D00_0000);

        check("stall_hold_violations", 32'(stall_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
